// File: rtl/alu_vector_driver.sv
// Drives pseudo-random vectors into a 4-bit ALU and checks each result against a golden model.
// Results are compacted into a MISR, and mismatches are counted with saturation; one vector is issued per cycle.
module alu_vector_driver #(
  parameter int          WIDTH = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic [15:0]      io_numVectors,
  input  logic [3:0]       io_opMask,
  output logic [WIDTH-1:0] io_alu_a,
  output logic [WIDTH-1:0] io_alu_b,
  output logic [1:0]       io_alu_opcode,
  input  logic [WIDTH-1:0] io_alu_out,
  output logic             io_busy,
  output logic             io_done,
  output logic [15:0]      io_signature,
  output logic [15:0]      io_mismatches
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      cnt_q;
  logic [3:0]       mask_q, eff_mask;
  logic             vld_q;
  logic [WIDTH-1:0] a_q, b_q, exp_d;
  logic [1:0]       op_q, op_d, low_op;
  logic             busy_q, done_q;
  logic [15:0]      sig_q, sig_d, mism_q, mism_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Disabled raw opcodes fall back to the lowest enabled one; an empty mask means add-only.
  assign eff_mask = (mask_q == 4'd0) ? 4'b0001 : mask_q;

  always_comb begin
    low_op = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eff_mask[k]) low_op = 2'(k);
    end
    op_d = eff_mask[lfsr_q[9:8]] ? lfsr_q[9:8] : low_op;
  end

  always_comb begin
    exp_d = '0;
    case (op_q)
      2'd0:    exp_d = a_q + b_q;
      2'd1:    exp_d = a_q - b_q;
      2'd2:    exp_d = a_q;
      default: exp_d = b_q;
    endcase
  end

  assign sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]}
                ^ {{(16-WIDTH){1'b0}}, io_alu_out};
  assign mism_d = ((io_alu_out != exp_d) && (mism_q != 16'hFFFF)) ? mism_q + 16'd1 : mism_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      mask_q  <= '0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= '0;
      mism_q  <= '0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      // The vector on the ALU pins was issued last cycle; its result is settled now.
      if (vld_q) begin
        sig_q  <= sig_d;
        mism_q <= mism_d;
      end
      case (state_q)
        IDLE: begin
          if (io_start) begin
            cnt_q  <= io_numVectors;
            mask_q <= io_opMask;
            sig_q  <= '0;
            mism_q <= '0;
            lfsr_q <= SEED;
            if (io_numVectors == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          a_q    <= lfsr_q[WIDTH-1:0];
          b_q    <= lfsr_q[2*WIDTH-1:WIDTH];
          op_q   <= op_d;
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q - 16'd1;
          vld_q  <= 1'b1;
          if (cnt_q == 16'd1) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_alu_a      = a_q;
  assign io_alu_b      = b_q;
  assign io_alu_opcode = op_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  assign io_signature  = sig_q;
  assign io_mismatches = mism_q;

endmodule

// File: tb/tb_alu_vector_driver.sv
// Bench for alu_vector_driver: behavioural ALU/stub on the pins, vector-level reference model.
module tb_alu_vector_driver;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset, io_start;
  logic [15:0] io_numVectors;
  logic [3:0]  io_opMask;
  logic [3:0]  io_alu_a, io_alu_b, io_alu_out;
  logic [1:0]  io_alu_opcode;
  logic        io_busy, io_done;
  logic [15:0] io_signature, io_mismatches;

  int checks = 0;
  int failures = 0;
  int alu_mode = 0;  // 0 correct ALU, 1 output stuck at 0, 2 corrupts LSB when a is odd

  always #5 clock = ~clock;

  alu_vector_driver dut (
    .clock(clock), .reset(reset), .io_start(io_start),
    .io_numVectors(io_numVectors), .io_opMask(io_opMask),
    .io_alu_a(io_alu_a), .io_alu_b(io_alu_b), .io_alu_opcode(io_alu_opcode),
    .io_alu_out(io_alu_out), .io_busy(io_busy), .io_done(io_done),
    .io_signature(io_signature), .io_mismatches(io_mismatches)
  );

  function automatic logic [3:0] golden(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a);
      default: r = int'(b);
    endcase
    return 4'(r % 16);
  endfunction

  function automatic logic [3:0] alu_model(input int mode, input logic [3:0] a,
                                           input logic [3:0] b, input logic [1:0] op);
    if (mode == 1) return 4'd0;
    if (mode == 2) return golden(a, b, op) ^ {3'b000, a[0]};
    return golden(a, b, op);
  endfunction

  assign io_alu_out = alu_model(alu_mode, io_alu_a, io_alu_b, io_alu_opcode);

  function automatic logic [1:0] pick_op(input logic [1:0] raw, input logic [3:0] mask);
    logic [3:0] m;
    m = (mask == 4'd0) ? 4'b0001 : mask;
    if (m[raw]) return raw;
    for (int k = 0; k < 4; k++) if (m[k]) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input logic [3:0] mask, input bit vec_chk, output int done_cyc);
    logic [15:0] l, s, m;
    logic [3:0]  qa[$], qb[$], va, vb, o;
    logic [1:0]  qo[$], vo;
    int          busy_cnt;
    l = SEED; s = '0; m = '0;
    for (int i = 0; i < n; i++) begin
      va = l[3:0]; vb = l[7:4]; vo = pick_op(l[9:8], mask);
      qa.push_back(va); qb.push_back(vb); qo.push_back(vo);
      o = alu_model(alu_mode, va, vb, vo);
      if (o != golden(va, vb, vo) && m != 16'hFFFF) m = m + 16'd1;
      s = shift16(s) ^ {12'b0, o};
      l = shift16(l);
    end
    @(negedge clock);
    io_start = 1'b1; io_numVectors = 16'(n); io_opMask = mask;
    @(posedge clock); #1;
    io_start = 1'b0;
    busy_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= n + 10; k++) begin
      if (io_busy) busy_cnt++;
      if (vec_chk && k >= 2 && k <= n + 1) begin
        chk("vec_a", io_alu_a, qa[k-2]);
        chk("vec_b", io_alu_b, qb[k-2]);
        chk("vec_op", io_alu_opcode, qo[k-2]);
        if (mask == 4'b0100) chk("passA_out", io_alu_out, io_alu_a);
      end
      if (io_done) begin
        done_cyc = k;
        break;
      end
      @(posedge clock); #1;
    end
    chk("done_cycle", done_cyc, (n == 0) ? 1 : n + 2);
    chk("busy_cycles", busy_cnt, (n == 0) ? 0 : n + 1);
    chk("signature", io_signature, s);
    chk("mismatches", io_mismatches, m);
    @(posedge clock); @(posedge clock); #1;
    chk("sig_hold", io_signature, s);
    chk("mism_hold", io_mismatches, m);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, io_alu_a, 0);
    chk({tag, "_b"}, io_alu_b, 0);
    chk({tag, "_op"}, io_alu_opcode, 0);
    chk({tag, "_busy"}, io_busy, 0);
    chk({tag, "_done"}, io_done, 0);
    chk({tag, "_sig"}, io_signature, 0);
    chk({tag, "_mism"}, io_mismatches, 0);
  endtask

  task automatic first_scenario(input string tag);
    int dc;
    alu_mode = 0;
    run(1, 4'hF, 1'b1, dc);
    chk({tag, "_a"}, io_alu_a, 4'h1);
    chk({tag, "_b"}, io_alu_b, 4'hE);
    chk({tag, "_op"}, io_alu_opcode, 2'b00);
    chk({tag, "_out"}, io_alu_out, 4'hF);
    chk({tag, "_sig"}, io_signature, 16'h000F);
    chk({tag, "_mism"}, io_mismatches, 0);
    chk({tag, "_done"}, dc, 3);
  endtask

  initial begin
    int dc;
    reset = 1'b1; io_start = 1'b0; io_numVectors = '0; io_opMask = '0;
    repeat (2) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock) reset = 1'b0;

    first_scenario("n1");

    alu_mode = 0;
    run(0, 4'hF, 1'b1, dc);
    chk("n0_sig", io_signature, 0);
    chk("n0_mism", io_mismatches, 0);

    run(16, 4'b0100, 1'b1, dc);
    chk("passA_mism", io_mismatches, 0);

    alu_mode = 1;
    run(8, 4'b1000, 1'b1, dc);

    for (int r = 0; r < 6; r++) begin
      alu_mode = int'($urandom_range(0, 2));
      run(int'($urandom_range(1, 40)), 4'($urandom_range(0, 15)), 1'b1, dc);
    end

    alu_mode = 1;
    run(65535, 4'b1000, 1'b0, dc);
    alu_mode = 0;
    run(3, 4'hF, 1'b1, dc);
    chk("second_run_mism", io_mismatches, 0);

    // Abort a long run in its fifth RUN cycle.
    @(negedge clock);
    io_start = 1'b1; io_numVectors = 16'd100; io_opMask = 4'hF;
    @(posedge clock); #1 io_start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    repeat (3) @(posedge clock);
    #1 chk("midreset_done", io_done, 0);
    chk("midreset_busy", io_busy, 0);
    @(negedge clock) reset = 1'b0;
    first_scenario("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_vector_driver.md
# alu_vector_driver

Stimulus/response driver for the 4-bit two-operand ALU characterised by the power/area flow: it generates pseudo-random operand/opcode vectors, drives the ALU's `io_a`/`io_b`/`io_opcode` inputs, and captures the ALU's `io_out`. It checks each result against an internal golden model and compacts all results into a MISR signature. It sits in the characterisation harness around the mapped ALU netlist, giving gate-level power runs a reproducible activity source and a self-check.

## Interface
- `WIDTH`, 4: ALU operand/result width. Only 4 is supported.
- `SEED`, 16'hACE1: LFSR reset/reload value. Must be nonzero.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_start`  in  1  one-cycle request to begin a run. Sampled only in IDLE.
- `io_numVectors`  in  16  number of vectors in the run. Sampled with `io_start`.
- `io_opMask`  in  4  enabled opcodes; bit k enables opcode k. Sampled with `io_start`.
- `io_alu_a`  out  4  ALU operand A (registered).
- `io_alu_b`  out  4  ALU operand B (registered).
- `io_alu_opcode`  out  2  ALU opcode (registered).
- `io_alu_out`  in  4  ALU result; combinational response to the `io_alu_*` outputs.
- `io_busy`  out  1  high while in RUN or DRAIN.
- `io_done`  out  1  one-cycle pulse at end of run.
- `io_signature`  out  16  MISR value.
- `io_mismatches`  out  16  count of golden-model mismatches, saturating.

## Operation
- ALU golden model, all results mod 16:
  - opcode 00: a+b
  - opcode 01: a−b
  - opcode 10: a
  - opcode 11: b
- LFSR: 16-bit Fibonacci, shifting left. feedback = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], feedback}.
- Vector fields: a = l[3:0], b = l[7:4], raw op = l[9:8].
- Opcode masking: if the raw op is disabled in the latched mask, use the lowest enabled opcode instead. A latched mask of 0 is treated as 4'b0001.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + `io_start`: latch `io_numVectors` and `io_opMask`; clear signature and mismatches; reload LFSR to SEED. Go to RUN, or to DONE if numVectors = 0.
  - RUN: each cycle, register one vector onto `io_alu_*`, advance the LFSR, decrement the remaining count. After the last vector is issued, go to DRAIN.
  - DRAIN: one cycle; samples the final result, then go to DONE.
  - DONE: assert `io_done` for one cycle, then go to IDLE.
- Result sampling: each cycle in which a vector registered on the previous cycle is valid (second RUN cycle onward, plus DRAIN):
  - Sample `io_alu_out` and compare it with the expected value, which is computed from a pipelined copy of the issued vector.
  - On a mismatch, increment `io_mismatches`; it saturates at 16'hFFFF.
  - Update the MISR: sig = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {12'b0, io_alu_out}.
- After DONE, `io_signature` and `io_mismatches` hold their values until the next accepted start.
- In IDLE and DONE, `io_alu_*` hold the last issued vector, so no extra toggling reaches the ALU.
- `io_start` while busy or in DONE is ignored.

## Timing
- Reset values:
  - FSM = IDLE; LFSR = SEED
  - `io_alu_a`/`b`/`opcode` = 0
  - `io_busy` = 0, `io_done` = 0
  - `io_signature` = 0, `io_mismatches` = 0
- Start accepted at edge T0: first vector appears on `io_alu_*` after edge T1. Its result is sampled at edge T2.
- A run of N ≥ 1 vectors:
  - RUN lasts N cycles, DRAIN 1 cycle, DONE 1 cycle.
  - `io_busy` is high for N+1 cycles.
  - `io_done` is high in cycle N+2 after the start edge. Final signature and mismatch count are valid in that same cycle.
- N = 0: `io_done` pulses the cycle after start. `io_busy` never rises. Signature = 0 and mismatches = 0.
- Throughput: one vector per cycle, no bubbles.
- Asynchronous `reset` mid-run:
  - All state and outputs return to reset values immediately; no `io_done` is issued.
  - A start after reset deassertion behaves as a fresh run.
- Width rules:
  - Adder/subtractor results are truncated to 4 bits; no carry/borrow is observed.
  - The remaining-vector counter is 16 bits, so N = 65535 is legal.

## Test plan
- Reset then start with N=1, mask=4'hF, loop ALU back correctly:
  - `io_alu_a`=1, `io_alu_b`=E, `io_alu_opcode`=00.
  - Expected result F; mismatches=0.
  - Signature=16'h000F; `io_done` at cycle 3.
- N=0 start → `io_done` on the next cycle; `io_busy` stays 0; signature=0.
- mask=4'b0100 (pass-A only), N=16, correct ALU:
  - Every issued opcode is 10 and `io_alu_out` equals `io_alu_a`.
  - mismatches=0.
- ALU stub forcing `io_alu_out`=0, N=8, mask=4'b1000: mismatches equals the count of vectors with b≠0.
- Mismatch saturation, stubbed wrong ALU, N=65535 then a second run:
  - First run: mismatches = number of vectors with b≠0, never wraps.
  - Second start: count clears to 0.
- `reset` asserted in RUN cycle 5 of N=100:
  - All outputs return to 0 within the reset cycle; no `io_done`.
  - A new N=1 run reproduces the first-scenario values exactly.
